// File: rtl/abc_input_debouncer.sv
// abc_input_debouncer: per-channel debounce of raw a/b/c inputs.
// Optional INPUT_SYNC_EN adds a two-flop synchronizer ahead of sampling.
module abc_input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_raw,
    input  logic       b_raw,
    input  logic       c_raw,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] changed_mask
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0] w_raw;
    logic [2:0] w_samp_d;
    logic [2:0] r_samp;
    logic [2:0] w_out;
    logic [2:0] w_pulse;

    assign w_raw = {c_raw, b_raw, a_raw};

`ifdef INPUT_SYNC_EN
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;

    // Two-flop synchronizer against metastability on async inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_samp_d = r_sync2;
`else
    assign w_samp_d = w_raw;
`endif

    // Sample flop feeding the per-channel debouncers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp <= '0;
        end else begin
            r_samp <= w_samp_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             r_out;
        logic             w_out_nxt;
        logic             r_pulse;
        logic             w_pulse_nxt;

        // Channel state, count, level and pulse registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
                r_out   <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_out   <= w_out_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        // Next-state: accept a new level after enough agreeing samples
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_out_nxt   = r_out;
            w_pulse_nxt = 1'b0;
            unique case (r_state)
                ST_STABLE: begin
                    if (r_samp[i] != r_out) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_out_nxt   = r_samp[i];
                            w_pulse_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_PEND;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                ST_PEND: begin
                    if (r_samp[i] == r_out) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == LAST_CNT) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                        w_out_nxt   = r_samp[i];
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_out[i]   = r_out;
        assign w_pulse[i] = r_pulse;
    end

    assign a            = w_out[0];
    assign b            = w_out[1];
    assign c            = w_out[2];
    assign changed_mask = w_pulse;

endmodule
